// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end.  Keeps an internal fetch PC (fpc), issues at
//   most one instruction-memory read at a time, and buffers returned words
//   together with their address in a small in-order queue.  The head entry is
//   presented to the datapath/control (Instr, PCPlus8) until accepted.
//   A redirect (taken branch / PC write) flushes the queue, reloads fpc and,
//   if a read is still in flight, lets it finish and throws its data away.
//
//   Build option (macro):
//     FETCH_PREFETCH_EN defined   -> 2-entry queue, 1 instr/cycle sustained
//     FETCH_PREFETCH_EN undefined -> 1-entry queue, 1 instr every 2 cycles
//
//   Ports
//     CLK, RESETn            clock (rising edge), async active-low reset
//     IMemReq / IMemAddr     read request and word-aligned byte address
//     IMemAck / IMemRData    read data valid for the current request / data
//     Instr / InstrValid     head-of-queue instruction and its valid
//     InstrReady             consumer accepts Instr this cycle
//     PCPlus8                head instruction address + 8 (fpc + 8 if empty)
//     Redirect / RedirectPC  flush + new fetch address
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESETn,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] PCPlus8,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t        q     [DEPTH];
  entry_t        q_nxt [DEPTH];
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   fpc;
  logic [31:0]   req_addr;   // address held while a request waits for its ack
  logic          pend;       // request issued in an earlier cycle, not yet acked
  logic          discard;    // in-flight request was overtaken by a redirect
  logic          ack, push, pop;
  logic          unused_redir;

  // Low two bits of the redirect target are dropped (word-aligned fetch).
  assign unused_redir = ^RedirectPC[1:0];

  // A waiting request keeps the bus; otherwise issue whenever there is room.
  // Only the registered count is used, so a same-cycle pop does not count.
  // RESETn gates the request so nothing is driven while in reset.
  assign IMemReq  = RESETn & (pend | (cnt < CW'(DEPTH)));
  // req_addr equals fpc unless a redirect moved fpc under a waiting request.
  assign IMemAddr = pend ? req_addr : fpc;

  assign ack  = IMemReq & IMemAck;
  assign push = ack & ~discard & ~Redirect;

  assign InstrValid = (cnt != '0);
  assign pop        = InstrValid & InstrReady & ~Redirect;
  assign Instr      = InstrValid ? q[0].instr : 32'h0;
  assign PCPlus8    = (InstrValid ? q[0].addr : fpc) + 32'd8;

  // Queue next state: head is always q[0]; pop shifts down, push lands
  // behind the last valid entry after any pop.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    if (Redirect) begin
      cnt_nxt = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) q_nxt[i] = q[i+1];
        cnt_nxt = cnt_nxt - CW'(1);
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == cnt_nxt) begin
            q_nxt[i].instr = IMemRData;
            q_nxt[i].addr  = IMemAddr;
          end
        end
        cnt_nxt = cnt_nxt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt      <= '0;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      pend     <= 1'b0;
      discard  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      cnt  <= cnt_nxt;
      q    <= q_nxt;
      pend <= IMemReq & ~IMemAck;
      if (IMemReq && !IMemAck && !pend) req_addr <= fpc;

      // A redirect against a request that is not acked this cycle marks it
      // stale; an ack in the redirect cycle is simply not pushed.
      if (Redirect)  discard <= IMemReq & ~IMemAck;
      else if (ack)  discard <= 1'b0;

      if (Redirect)  fpc <= {RedirectPC[31:2], 2'b00};
      else if (push) fpc <= fpc + 32'd4;   // wraps modulo 2^32
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit.  A memory model answers requests after a
//   programmable wait (word n lives at address 4n).  Each phase pushes the
//   instructions it expects into a queue; a monitor pops and compares them
//   whenever the DUT hands one over.  A second instance with RESET_PC near the
//   top of the address space checks fetch-address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        IMemReq, IMemAck, InstrValid, InstrReady, Redirect;
  logic [31:0] IMemAddr, IMemRData, Instr, PCPlus8, RedirectPC;
  int          lat;
  logic        ack_force;
  int          wcnt;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc8_2;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RESETn(RESETn),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady), .PCPlus8(PCPlus8),
    .Redirect(Redirect), .RedirectPC(RedirectPC)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RESETn(RESETn),
    .IMemReq(req2), .IMemAddr(addr2), .IMemAck(req2), .IMemRData(addr2 >> 2),
    .Instr(instr2), .InstrValid(valid2), .InstrReady(1'b1), .PCPlus8(pc8_2),
    .Redirect(1'b0), .RedirectPC(32'h0)
  );

  // Memory model: ack once the request has waited 'lat' cycles.
  assign IMemAck   = ack_force | (IMemReq && (wcnt == lat));
  assign IMemRData = IMemAddr >> 2;

  always @(posedge CLK or negedge RESETn)
    if (!RESETn)                 wcnt <= 0;
    else if (IMemReq && !IMemAck) wcnt <= wcnt + 1;
    else                          wcnt <= 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] a2_q[$];
  int ntests = 0, nfail = 0, npop = 0, cyc = 0, first_pop = -1, last_pop = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (RESETn && InstrValid && InstrReady) begin
      if (exp_q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL sb_extra: got instr %h pc8 %h, required no delivery", Instr, PCPlus8);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", Instr, e.instr);
        chk("sb_pc8", PCPlus8, e.pc8);
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      npop++;
    end
  end

  // First three fetch addresses of the wrap instance.
  always @(negedge CLK)
    if (RESETn && req2 && a2_q.size() < 3) a2_q.push_back(addr2);

  task automatic wait_pops(int n);
    int target;
    target = npop + n;
    for (int k = 0; k < 300 && npop < target; k++) begin
      @(negedge CLK); #1;
    end
    chk("pop_timeout", 32'(npop >= target), 32'd1);
    @(posedge CLK); #1;
    InstrReady = 1'b0;
  endtask

  // Enter reset, settle, and return at a negedge with RESETn still low.
  task automatic start(int l, logic rdy);
    @(negedge CLK);
    RESETn = 1'b0;
    chk("sb_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    lat = l; InstrReady = rdy; Redirect = 1'b0; RedirectPC = 32'h0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_exp [3];
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    RESETn = 1'b0; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    lat = 0; ack_force = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset values
    chk("rst_req",   IMemReq,    0);
    chk("rst_addr",  IMemAddr,   0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr,      0);
    chk("rst_pc8",   PCPlus8,    32'd8);
    chk("rst2_addr", addr2,      32'hFFFF_FFF8);
    chk("rst2_pc8",  pc8_2,      32'h0);

    // Streaming, zero-wait memory
    for (int n = 0; n < 8; n++) exp_q.push_back('{32'(n), 32'(4*n + 8)});
    InstrReady = 1'b1;
    RESETn = 1'b1; #1;
    chk("first_req",  IMemReq,  1);
    chk("first_addr", IMemAddr, 0);
    first_pop = -1;
    wait_pops(8);
    chk("stream_gap", 32'(last_pop - first_pop), 32'(7 * GAP));

    // Consumer stall for 5 cycles, then drain in order
    start(0, 1'b0);
    for (int n = 0; n < 6; n++) exp_q.push_back('{32'(n), 32'(4*n + 8)});
    RESETn = 1'b1;
    repeat (5) @(posedge CLK); #1;
    chk("stall_req",   IMemReq,    0);
    chk("stall_valid", InstrValid, 1);
    chk("stall_instr", Instr,      0);
    chk("stall_pc8",   PCPlus8,    32'd8);
    InstrReady = 1'b1;
    wait_pops(6);

    // Redirect while a 3-wait request is outstanding
    start(3, 1'b1);
    exp_q.push_back('{32'h40, 32'h108});
    exp_q.push_back('{32'h41, 32'h10C});
    RESETn = 1'b1; #1;
    chk("w_req0", IMemReq, 1);
    @(posedge CLK); #1;
    Redirect = 1'b1; RedirectPC = 32'h103;
    @(posedge CLK); #1;
    Redirect = 1'b0;
    chk("wait_req",  IMemReq,  1);
    chk("wait_addr", IMemAddr, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("stale_drop", InstrValid, 0);
    chk("redir_req",  IMemReq,    1);
    chk("redir_addr", IMemAddr,   32'h100);
    wait_pops(2);

    // Redirect in the ack cycle, then redirect on a full queue
    start(0, 1'b0);
    Redirect = 1'b1; RedirectPC = 32'h40;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    Redirect = 1'b0;
    chk("same_cyc_empty", InstrValid, 0);
    chk("same_cyc_addr",  IMemAddr,   32'h40);
    @(posedge CLK); #1;
    chk("redir_valid", InstrValid, 1);
    chk("redir_instr", Instr,      32'h10);
    chk("redir_pc8",   PCPlus8,    32'h48);
    repeat (3) @(posedge CLK); #1;
    chk("full_noreq", IMemReq, 0);
    Redirect = 1'b1; RedirectPC = 32'h80;
    @(posedge CLK); #1;
    Redirect = 1'b0;
    chk("flush_empty", InstrValid, 0);
    exp_q.push_back('{32'h20, 32'h88});
    InstrReady = 1'b1;
    wait_pops(1);

    // Asynchronous reset in the middle of a request
    start(3, 1'b1);
    exp_q.push_back('{32'h0, 32'h8});
    RESETn = 1'b1;
    repeat (6) @(posedge CLK); #1;
    chk("midreq_req",  IMemReq,  1);
    chk("midreq_addr", IMemAddr, 32'h4);
    #2 RESETn = 1'b0;
    #1;
    chk("async_req",   IMemReq,    0);
    chk("async_addr",  IMemAddr,   0);
    chk("async_valid", InstrValid, 0);
    chk("async_instr", Instr,      0);
    chk("async_pc8",   PCPlus8,    32'd8);
    ack_force = 1'b1;
    @(posedge CLK); #1;
    ack_force = 1'b0;
    chk("rst_ack_valid", InstrValid, 0);
    chk("rst_ack_addr",  IMemAddr,   0);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Fetch-address wrap on the second instance
    chk("wrap_n", a2_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("wrap_addr", (i < a2_q.size()) ? a2_q[i] : 32'hxxxx_xxxx, wrap_exp[i]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
